pix_lane_gather: RTL and testbench
==================================

# pix_lane_gather

Front end of the sub-pixel delay path. It collects a serial stream of 14-bit pixels, one per cycle, into 4-lane parallel beats for the 4-lane fractional-delay interpolator, and drives the beat index (`clk_cnt`) and the per-line shift configuration that the interpolator consumes. At line end it pads a partial beat by edge replication, then emits one flush beat so the interpolator's last lane-3 pixel has a valid next neighbour.

## Interface
- `L`, 4: lanes per beat; fixed at 4 for this release.
- `DW`, 14: pixel width.
- `CNT_W`, 10: beat counter width.
- `clk` in 1: single clock; all logic on posedge.
- `reset` in 1: asynchronous, active-low reset.
- `pix_in` in DW: serial pixel.
- `pix_in_v` in 1: pixel valid. There is no backpressure; every valid pixel must be taken.
- `pix_in_sol` in 1: start of line; qualified by `pix_in_v`.
- `pix_in_eol` in 1: end of line; qualified by `pix_in_v`.
- `cfg_fract_steps` in 8: fractional step for the next line.
- `cfg_shift_dir` in 1: shift direction for the next line.
- `err_clr` in 1: clears sticky errors.
- `sample_out0..3` out DW: lane 0..3 pixels. Lane 0 holds the earliest pixel.
- `sample_out_v` out 1: beat valid; a 1-cycle pulse per beat.
- `sample_out_last` out 1: marks the flush beat.
- `clk_cnt` out CNT_W: beat index within the line. It is 1 on the first beat.
- `fract_steps` out 8, `shift_dir` out 1: active line configuration.
- `err_sync` out 1: sticky; set on a framing violation.
- `err_ovf` out 1: sticky; set on beat counter saturation.

## Operation
- FSM states are IDLE, ACTIVE and FLUSH.
- **IDLE**
  - `pix_in_v & pix_in_sol`: the pixel goes to slot 0, `cfg_*` is captured into the pending registers, and the FSM moves to ACTIVE.
  - `pix_in_v` without `sol`: the pixel is dropped and `err_sync` is set.
- **ACTIVE** handles each valid pixel as follows:
  - The pixel is written to the current slot (0..3).
  - When slot 3 is filled, a beat is emitted and the slot pointer returns to 0.
  - When `eol` arrives in slot s < 3, slots s+1..3 are filled with the same pixel and a beat is emitted. A 1-pixel line (sol and eol together) gives four copies.
  - After any `eol` the FSM moves to FLUSH.
- **ACTIVE + sol (no prior eol)**
  - The partial beat is discarded and `err_sync` is set.
  - A new line restarts with this pixel in slot 0, cfg is recaptured and `clk_cnt` restarts.
  - No flush beat is produced for the aborted line.
- **FLUSH** lasts exactly 1 cycle.
  - It emits a beat of four copies of the last pixel, with `sample_out_last`=1 and `clk_cnt` = previous + 1.
  - It then moves to IDLE.
  - A valid pixel with `sol` in this cycle is accepted exactly as in IDLE and the FSM moves to ACTIVE.
  - A valid pixel without `sol` in this cycle is dropped and `err_sync` is set.
- **Configuration**
  - `fract_steps`/`shift_dir` load from the pending registers on the edge that emits beat 1 of a line.
  - They are stable for the whole line, including its flush beat.
- **Beat counter**
  - `clk_cnt` increments per emitted beat and saturates at 2^CNT_W−1.
  - Any attempted increment past saturation sets `err_ovf`; beats are still emitted with `clk_cnt` held.
  - The counter resets to 0 on return to IDLE; the value is held on the outputs until the next beat.
- `err_clr` clears both sticky errors. If a set and `err_clr` occur in the same cycle, set wins.

## Timing
- All outputs are registered.
- Reset values: all `sample_out*`, `clk_cnt`, `fract_steps`, `shift_dir`, `sample_out_v`, `sample_out_last`, `err_*` are 0; the FSM is in IDLE with the slot pointer at 0.
- Latency: `sample_out_v` rises 1 cycle after the edge that samples the pixel completing a beat (slot 3 or eol).
- The flush beat follows on the next cycle, so a line ending in a full beat gives two consecutive `sample_out_v` cycles.
- Sample outputs hold their last value while `sample_out_v`=0.
- Reset mid-line aborts immediately. No flush beat is emitted after reset deassertion.

## Structure
- Shared package `pix_pkg`: `DW`, `L`, `CNT_W`, the FSM state enum (`PG_IDLE`, `PG_ACTIVE`, `PG_FLUSH`), and the pixel typedef `pix_t` (logic [DW-1:0]). The interpolator stage imports the same package.
- Single module; no sub-module is warranted. The slot array and padding mux are local.

## Test plan
- **Full-beat line.** An 8-pixel line with values 1..8, sol on 1 and eol on 8, must produce:
  - beat (1,2,3,4) with cnt 1;
  - beat (5,6,7,8) with cnt 2;
  - next cycle, (8,8,8,8) with cnt 3 and last=1.
- **Padded line.** A 6-pixel line with values 10..15 must produce:
  - beat (10,11,12,13) with cnt 1;
  - beat (14,15,15,15) with cnt 2;
  - flush beat (15,15,15,15) with cnt 3 and last=1.
- **Config timing and back-to-back lines.** Set cfg to 0x40/1 at the first line's sol and to 0x10/0 at the second line's sol, which arrives in the FLUSH cycle. Required:
  - outputs show 0x40/1 through the first flush beat;
  - outputs show 0x10/0 from the second line's beat 1;
  - no pixel is lost.
- **Framing errors.** A pixel without sol in IDLE, then a second sol mid-line after 2 pixels. Required:
  - `err_sync` is set;
  - the partial data is discarded and the new line starts at cnt 1;
  - `err_clr` then clears the flag.
- **Saturation.** A line of 4100 pixels must hold `clk_cnt` at 1023, set `err_ovf`, and still produce a flush beat with last=1.
- **Async reset mid-line.** Assert reset asynchronously after 3 pixels. All outputs must be 0 immediately and no flush beat may follow; the next sol line must start at cnt 1.

Source files
------------

// File: rtl/pix_pkg.sv
// Shared definitions for the sub-pixel delay path: geometry, pixel type and
// the gather-stage FSM encoding.
package pix_pkg;

  localparam int DW    = 14;
  localparam int L     = 4;
  localparam int CNT_W = 10;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [DW-1:0] pix_t;

  typedef enum logic [1:0] {
    PG_IDLE   = 2'd0,
    PG_ACTIVE = 2'd1,
    PG_FLUSH  = 2'd2
  } pg_state_t;

  function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_MAX) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/pix_lane_gather.sv
// Gathers a serial pixel stream into 4-lane beats, edge-pads the last beat of
// each line and appends one flush beat so lane 3 always has a next neighbour.
module pix_lane_gather
  import pix_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  pix_t             pix_in,
  input  logic             pix_in_v,
  input  logic             pix_in_sol,
  input  logic             pix_in_eol,
  input  logic [7:0]       cfg_fract_steps,
  input  logic             cfg_shift_dir,
  input  logic             err_clr,
  output pix_t             sample_out0,
  output pix_t             sample_out1,
  output pix_t             sample_out2,
  output pix_t             sample_out3,
  output logic             sample_out_v,
  output logic             sample_out_last,
  output logic [CNT_W-1:0] clk_cnt,
  output logic [7:0]       fract_steps,
  output logic             shift_dir,
  output logic             err_sync,
  output logic             err_ovf,
  output pg_state_t        dbg_state
);

  // Handshake: pix_in_v is a valid-only strobe with no ready; every cycle with
  // pix_in_v=1 is consumed (stored or dropped with err_sync), and sample_out_v
  // is a one-cycle pulse per beat that the consumer must take.

  pg_state_t        state;
  logic [1:0]       ptr;
  pix_t             slot_q [L];
  pix_t             last_pix;
  logic [CNT_W-1:0] cnt;
  logic [7:0]       pend_fract;
  logic             pend_dir;
  logic             solo_q;

  logic             take;
  logic             sync_err;
  logic [1:0]       eff_ptr;
  logic [CNT_W-1:0] eff_cnt;
  logic             pix_done;
  logic             flush_now;
  logic             emit_pix;
  logic             emit;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] cnt_inc;
  logic             load_cfg;
  logic             ovf_hit;
  pix_t             beat [L];

  assign dbg_state = state;

  always_comb begin
    flush_now = (state == PG_FLUSH);
    // A single-pixel line arriving in the flush cycle cannot share that beat
    // slot; its data beat goes out one cycle later (solo_q) and pixels in that
    // slot are framing errors.
    take      = pix_in_v && !solo_q && (pix_in_sol || state == PG_ACTIVE);
    sync_err  = pix_in_v && (solo_q || (pix_in_sol == (state == PG_ACTIVE)));
    eff_ptr   = pix_in_sol ? 2'd0 : ptr;
    eff_cnt   = pix_in_sol ? '0 : cnt;
    pix_done  = take && (eff_ptr == 2'd3 || pix_in_eol);
    emit_pix  = pix_done && !flush_now;
    emit      = emit_pix || flush_now || solo_q;
    base_cnt  = emit_pix ? eff_cnt : cnt;
    cnt_inc   = cnt_sat_inc(base_cnt);
    load_cfg  = emit && (base_cnt == '0);
    ovf_hit   = emit && (base_cnt == CNT_MAX);
    for (int i = 0; i < L; i++) begin
      if (emit_pix)
        beat[i] = (2'(i) >= eff_ptr) ? pix_in : slot_q[i];
      else
        beat[i] = last_pix;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= PG_IDLE;
      ptr             <= '0;
      for (int i = 0; i < L; i++) slot_q[i] <= '0;
      last_pix        <= '0;
      cnt             <= '0;
      pend_fract      <= '0;
      pend_dir        <= 1'b0;
      solo_q          <= 1'b0;
      sample_out0     <= '0;
      sample_out1     <= '0;
      sample_out2     <= '0;
      sample_out3     <= '0;
      sample_out_v    <= 1'b0;
      sample_out_last <= 1'b0;
      clk_cnt         <= '0;
      fract_steps     <= '0;
      shift_dir       <= 1'b0;
      err_sync        <= 1'b0;
      err_ovf         <= 1'b0;
    end else begin
      if (take) begin
        slot_q[eff_ptr] <= pix_in;
        last_pix        <= pix_in;
        ptr             <= pix_done ? 2'd0 : eff_ptr + 2'd1;
        if (pix_in_sol) begin
          pend_fract <= cfg_fract_steps;
          pend_dir   <= cfg_shift_dir;
        end
      end

      if (emit_pix || solo_q)
        cnt <= cnt_inc;
      else if (flush_now || (take && pix_in_sol))
        cnt <= '0;

      case (state)
        PG_IDLE:
          if (take) state <= pix_in_eol ? PG_FLUSH : PG_ACTIVE;
        PG_ACTIVE:
          if (solo_q) begin
            state  <= PG_FLUSH;
            solo_q <= 1'b0;
          end else if (take && pix_in_eol) begin
            state <= PG_FLUSH;
          end
        PG_FLUSH:
          if (take) begin
            state  <= PG_ACTIVE;
            solo_q <= pix_done;
          end else begin
            state <= PG_IDLE;
          end
        default: state <= PG_IDLE;
      endcase

      sample_out_v    <= emit;
      sample_out_last <= flush_now;
      if (emit) begin
        sample_out0 <= beat[0];
        sample_out1 <= beat[1];
        sample_out2 <= beat[2];
        sample_out3 <= beat[3];
        clk_cnt     <= cnt_inc;
      end
      // Beat 1 of a line latches the line config; a sol pixel that also ends
      // its first beat has not reached the pending registers yet.
      if (load_cfg) begin
        fract_steps <= (take && pix_in_sol) ? cfg_fract_steps : pend_fract;
        shift_dir   <= (take && pix_in_sol) ? cfg_shift_dir : pend_dir;
      end

      err_sync <= sync_err | (err_sync & ~err_clr);
      err_ovf  <= ovf_hit | (err_ovf & ~err_clr);
    end
  end

endmodule

// File: tb/tb_pix_lane_gather.sv
// Randomized and directed bench for pix_lane_gather against a line-level
// reference model that chunks each line into padded beats plus a flush beat.
module tb_pix_lane_gather;
  import pix_pkg::*;

  logic             clk;
  logic             reset;
  pix_t             pix_in;
  logic             pix_in_v;
  logic             pix_in_sol;
  logic             pix_in_eol;
  logic [7:0]       cfg_fract_steps;
  logic             cfg_shift_dir;
  logic             err_clr;
  pix_t             sample_out0, sample_out1, sample_out2, sample_out3;
  logic             sample_out_v;
  logic             sample_out_last;
  logic [CNT_W-1:0] clk_cnt;
  logic [7:0]       fract_steps;
  logic             shift_dir;
  logic             err_sync;
  logic             err_ovf;
  pg_state_t        dbg_state;

  pix_lane_gather dut (
    .clk             (clk),
    .reset           (reset),
    .pix_in          (pix_in),
    .pix_in_v        (pix_in_v),
    .pix_in_sol      (pix_in_sol),
    .pix_in_eol      (pix_in_eol),
    .cfg_fract_steps (cfg_fract_steps),
    .cfg_shift_dir   (cfg_shift_dir),
    .err_clr         (err_clr),
    .sample_out0     (sample_out0),
    .sample_out1     (sample_out1),
    .sample_out2     (sample_out2),
    .sample_out3     (sample_out3),
    .sample_out_v    (sample_out_v),
    .sample_out_last (sample_out_last),
    .clk_cnt         (clk_cnt),
    .fract_steps     (fract_steps),
    .shift_dir       (shift_dir),
    .err_sync        (err_sync),
    .err_ovf         (err_ovf),
    .dbg_state       (dbg_state)
  );

  localparam int BW = 1 + CNT_W + 8 + 1 + 4 * DW;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  logic [BW-1:0] held;
  pix_t          line_px[$];
  int            n_chk;
  int            n_pass;

  task automatic check(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
  endtask

  function automatic logic [BW-1:0] pack(input logic lst, input logic [CNT_W-1:0] c,
                                         input logic [7:0] f, input logic d,
                                         input pix_t a0, input pix_t a1,
                                         input pix_t a2, input pix_t a3);
    return {lst, c, f, d, a0, a1, a2, a3};
  endfunction

  function automatic logic [CNT_W-1:0] sat(input int k);
    return (k > 1023) ? CNT_W'(1023) : CNT_W'(k);
  endfunction

  function automatic logic [BW-1:0] obs_beat();
    return pack(sample_out_last, clk_cnt, fract_steps, shift_dir,
                sample_out0, sample_out1, sample_out2, sample_out3);
  endfunction

  // Expected beats for the line in line_px: groups of four, last group padded
  // with the final pixel, then a flush beat of four copies.
  task automatic model_line(input logic [7:0] f, input logic d);
    int n;
    int nb;
    pix_t p[4];
    n  = line_px.size();
    nb = (n + 3) / 4;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 4; j++) begin
        int idx;
        idx  = 4 * b + j;
        if (idx > n - 1) idx = n - 1;
        p[j] = line_px[idx];
      end
      exp_q.push_back(pack(1'b0, sat(b + 1), f, d, p[0], p[1], p[2], p[3]));
    end
    exp_q.push_back(pack(1'b1, sat(nb + 1), f, d, line_px[n-1], line_px[n-1],
                         line_px[n-1], line_px[n-1]));
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      held = '0;
    end else if (sample_out_v) begin
      if (exp_q.size() == 0) check("unexpected_beat", 80'(obs_beat()), 80'(0));
      else check("beat", 80'(obs_beat()), 80'(exp_q.pop_front()));
      held = obs_beat();
      held[BW-1] = 1'b0;
    end else begin
      check("hold", 80'(obs_beat()), 80'(held));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pix(input pix_t p, input logic sol, input logic eol);
    pix_in     = p;
    pix_in_v   = 1'b1;
    pix_in_sol = sol;
    pix_in_eol = eol;
    @(posedge clk);
    #1;
    pix_in_v   = 1'b0;
    pix_in_sol = 1'b0;
    pix_in_eol = 1'b0;
    pix_in     = pix_t'($urandom);
  endtask

  // Drives line_px as one line; cfg is only meaningful on the sol pixel, so it
  // is scrambled afterwards. bubble_pct inserts idle cycles between pixels.
  task automatic send_line(input logic [7:0] f, input logic d, input int bubble_pct);
    int n;
    n = line_px.size();
    model_line(f, d);
    for (int i = 0; i < n; i++) begin
      if (i == 0) begin
        cfg_fract_steps = f;
        cfg_shift_dir   = d;
      end
      drive_pix(line_px[i], i == 0, i == n - 1);
      cfg_fract_steps = 8'($urandom);
      cfg_shift_dir   = 1'($urandom);
      if (i < n - 1 && int'($urandom_range(0, 99)) < bubble_pct)
        idle(int'($urandom_range(1, 2)));
    end
  endtask

  task automatic make_seq(input int n, input int first);
    line_px.delete();
    for (int i = 0; i < n; i++) line_px.push_back(pix_t'(first + i));
  endtask

  task automatic make_rand(input int n);
    line_px.delete();
    for (int i = 0; i < n; i++) line_px.push_back(pix_t'($urandom));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len;
    int gap;
    int prev_gap_ok;
    n_chk = 0;
    n_pass = 0;
    held = '0;
    reset = 1'b0;
    pix_in = '0;
    pix_in_v = 1'b0;
    pix_in_sol = 1'b0;
    pix_in_eol = 1'b0;
    cfg_fract_steps = '0;
    cfg_shift_dir = 1'b0;
    err_clr = 1'b0;
    #12;
    check("rst_outs", 80'({obs_beat(), sample_out_v, err_sync, err_ovf}), 80'(0));
    check("rst_state", 80'(dbg_state), 80'(PG_IDLE));
    idle(1);
    reset = 1'b1;
    idle(2);

    // Full-beat line 1..8, with the two back-to-back valid cycles at the end.
    make_seq(8, 1);
    send_line(8'h22, 1'b1, 0);
    @(negedge clk);
    check("full_v_beat2", 80'({sample_out_v, sample_out_last}), 80'(2'b10));
    @(negedge clk);
    check("full_v_flush", 80'({sample_out_v, sample_out_last}), 80'(2'b11));
    idle(3);

    // Padded line 10..15.
    make_seq(6, 10);
    send_line(8'h05, 1'b0, 0);
    idle(4);

    // Back-to-back lines: second sol lands in the flush cycle.
    make_rand(8);
    send_line(8'h40, 1'b1, 0);
    make_rand(5);
    send_line(8'h10, 1'b0, 0);
    idle(4);
    check("cfg_second", 80'({fract_steps, shift_dir}), 80'({8'h10, 1'b0}));

    // Framing errors: stray pixel in IDLE, then a restart mid-line.
    check("sync_clear0", 80'(err_sync), 80'(0));
    drive_pix(pix_t'(14'h123), 1'b0, 1'b0);
    check("sync_stray", 80'(err_sync), 80'(1));
    idle(2);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("sync_clr1", 80'(err_sync), 80'(0));
    drive_pix(pix_t'(14'h0aa), 1'b1, 1'b0);
    drive_pix(pix_t'(14'h0bb), 1'b0, 1'b0);
    make_seq(5, 200);
    send_line(8'h77, 1'b1, 0);
    check("sync_restart", 80'(err_sync), 80'(1));
    idle(4);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("sync_clr2", 80'(err_sync), 80'(0));

    // Randomized lines with bubbles and random inter-line gaps.
    prev_gap_ok = 1;
    for (int k = 0; k < 40; k++) begin
      len = int'($urandom_range(1, 13));
      if (len == 1 && !prev_gap_ok) idle(1);
      make_rand(len);
      send_line(8'($urandom), 1'($urandom), 20);
      gap = int'($urandom_range(0, 3));
      if (gap > 0) idle(gap);
      prev_gap_ok = (gap > 0);
    end
    idle(4);
    check("rand_no_sync", 80'(err_sync), 80'(0));
    check("rand_no_ovf", 80'(err_ovf), 80'(0));

    // Saturation: 4100 pixels -> 1025 data beats, counter pinned at 1023.
    make_rand(4100);
    send_line(8'h3c, 1'b1, 0);
    idle(4);
    check("sat_ovf", 80'(err_ovf), 80'(1));
    check("sat_cnt", 80'(clk_cnt), 80'(1023));

    // Async reset mid-line.
    drive_pix(pix_t'(14'h301), 1'b1, 1'b0);
    drive_pix(pix_t'(14'h302), 1'b0, 1'b0);
    drive_pix(pix_t'(14'h303), 1'b0, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst", 80'({obs_beat(), sample_out_v, err_sync, err_ovf}), 80'(0));
    idle(2);
    reset = 1'b1;
    idle(6);
    check("rst_no_flush", 80'(clk_cnt), 80'(0));
    make_seq(5, 500);
    send_line(8'h99, 1'b0, 0);
    idle(6);

    check("queue_empty", 80'(exp_q.size()), 80'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
